// File: rtl/br_ctrl_pkg.sv
// Shared definitions for ID-stage branch control: FSM states and comparator forwarding codes.
package br_ctrl_pkg;

    typedef enum logic {
        RESOLVE = 1'b0,
        WAIT    = 1'b1
    } br_state_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/id_hazard_detect.sv
// Per-operand RAW hazard check for the ID branch comparator: how many hold cycles are needed
// before the operand is forwardable, and which source feeds the comparator.
module id_hazard_detect
    import br_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            id_branch,
    input  logic [RA_W-1:0] rs,
    input  logic            ex_regwrite,
    input  logic            ex_memread,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            mem_regwrite,
    input  logic            mem_memread,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            wb_regwrite,
    input  logic [RA_W-1:0] wb_rd,
    output logic [1:0]      need,
    output logic [1:0]      fwd
);

    logic rs_live;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;
    logic [1:0] raw_need;

    // rs==0 can never match, so a producer writing x0 is never seen as a hazard.
    assign rs_live = (rs != '0);
    assign ex_hit  = rs_live && (ex_rd == rs);
    assign mem_hit = rs_live && (mem_rd == rs);
    assign wb_hit  = rs_live && (wb_rd == rs);

    always_comb begin
        raw_need = 2'd0;
        fwd      = FWD_RF;
        if (ex_hit && ex_memread) begin
            raw_need = 2'd2;
        end else if (ex_hit && ex_regwrite) begin
            raw_need = 2'd1;
        end else if (mem_hit && mem_memread) begin
            raw_need = 2'd1;
        end else if (mem_hit && mem_regwrite) begin
            fwd = FWD_MEM;
        end else if (wb_hit && wb_regwrite) begin
            fwd = FWD_WB;
        end
    end

    // Forwarding is still reported for non-branches; only the hold request is branch-qualified.
    assign need = id_branch ? raw_need : 2'd0;

endmodule

// File: rtl/id_branch_ctrl.sv
// ID-stage branch sequencer: holds the pipeline until comparator operands are forwardable,
// redirects PC / flushes IF/ID on a taken branch, and keeps saturating branch counters.
module id_branch_ctrl
    import br_ctrl_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             ID_Branch_i,
    input  logic [RA_W-1:0]  ID_rs1_i,
    input  logic [RA_W-1:0]  ID_rs2_i,
    input  logic             EX_RegWrite_i,
    input  logic             EX_MemRead_i,
    input  logic [RA_W-1:0]  EX_rd_i,
    input  logic             MEM_RegWrite_i,
    input  logic             MEM_MemRead_i,
    input  logic [RA_W-1:0]  MEM_rd_i,
    input  logic             WB_RegWrite_i,
    input  logic [RA_W-1:0]  WB_rd_i,
    input  logic             Branch_i,
    output logic [1:0]       fwd1_sel_o,
    output logic [1:0]       fwd2_sel_o,
    output logic             stall_o,
    output logic             pc_sel_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o,
    output logic [CNT_W-1:0] hold_cnt_o,
    output logic             dbg_state_o
);

    br_state_t  state;
    logic [1:0] wait_cnt;
    logic [1:0] need1;
    logic [1:0] need2;
    logic [1:0] need;
    logic       active;
    logic       hold;
    logic       resolving;

    id_hazard_detect #(.RA_W(RA_W)) u_hz1 (
        .id_branch   (ID_Branch_i),
        .rs          (ID_rs1_i),
        .ex_regwrite (EX_RegWrite_i),
        .ex_memread  (EX_MemRead_i),
        .ex_rd       (EX_rd_i),
        .mem_regwrite(MEM_RegWrite_i),
        .mem_memread (MEM_MemRead_i),
        .mem_rd      (MEM_rd_i),
        .wb_regwrite (WB_RegWrite_i),
        .wb_rd       (WB_rd_i),
        .need        (need1),
        .fwd         (fwd1_sel_o)
    );

    id_hazard_detect #(.RA_W(RA_W)) u_hz2 (
        .id_branch   (ID_Branch_i),
        .rs          (ID_rs2_i),
        .ex_regwrite (EX_RegWrite_i),
        .ex_memread  (EX_MemRead_i),
        .ex_rd       (EX_rd_i),
        .mem_regwrite(MEM_RegWrite_i),
        .mem_memread (MEM_MemRead_i),
        .mem_rd      (MEM_rd_i),
        .wb_regwrite (WB_RegWrite_i),
        .wb_rd       (WB_rd_i),
        .need        (need2),
        .fwd         (fwd2_sel_o)
    );

    assign need = (need1 > need2) ? need1 : need2;

    // A global stall already freezes the pipeline, so this block stays silent and frozen under it.
    assign active    = !stall_i && !rst;
    assign hold      = active && ((state == WAIT) || (need != 2'd0));
    assign resolving = active && (state == RESOLVE) && ID_Branch_i && (need == 2'd0);

    assign stall_o     = hold;
    assign pc_sel_o    = resolving && Branch_i;
    assign flush_o     = resolving && Branch_i;
    assign dbg_state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RESOLVE;
            wait_cnt    <= 2'd0;
            br_cnt_o    <= '0;
            taken_cnt_o <= '0;
            hold_cnt_o  <= '0;
        end else if (!stall_i) begin
            case (state)
                RESOLVE: begin
                    if (need != 2'd0) begin
                        wait_cnt <= need - 2'd1;
                        state    <= (need == 2'd1) ? RESOLVE : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 2'd1;
                    if (wait_cnt == 2'd1) state <= RESOLVE;
                end
                default: state <= RESOLVE;
            endcase
            // Counters saturate at all-ones.
            if (resolving && (br_cnt_o != '1)) br_cnt_o <= br_cnt_o + 1'b1;
            if (resolving && Branch_i && (taken_cnt_o != '1)) taken_cnt_o <= taken_cnt_o + 1'b1;
            if (hold && (hold_cnt_o != '1)) hold_cnt_o <= hold_cnt_o + 1'b1;
        end
    end

endmodule
